// File: rtl/two_port_ram_be_pipe.sv
// Single-clock two-port RAM with per-byte write enables, a 1- or 2-cycle read
// pipeline, read-valid strobe and selectable same-address read/write policy.
module two_port_ram_be_pipe #(
    parameter int DATA_W = 2048,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w_en,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W/8-1:0] w_be,
    input  logic [DATA_W-1:0]   w_data,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid
);

    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("two_port_ram_be_pipe: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("two_port_ram_be_pipe: DATA_W must be a multiple of 8");
    end
    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr
        $error("two_port_ram_be_pipe: 2**ADDR_W must cover DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              w_in_range_s;
    logic              r_in_range_s;
    logic              w_fire_s;
    logic              r_fire_s;
    logic [DATA_W-1:0] rd_word_s;

    assign w_in_range_s = ({1'b0, w_addr} < DEPTH_L);
    assign r_in_range_s = ({1'b0, r_addr} < DEPTH_L);
    assign w_fire_s     = rst_n & w_en & w_in_range_s;
    assign r_fire_s     = rst_n & r_en;

    // Array write, byte-granular; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_fire_s) begin
            for (int i = 0; i < BYTES; i++) begin
                if (w_be[i]) begin
                    mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Read word selection: out-of-range reads yield zero, write-first merges
    // the enabled bytes of a same-edge write into the returned word.
    always_comb begin
        rd_word_s = '0;
        if (r_in_range_s) begin
            rd_word_s = mem[r_addr];
            if (BYPASS == 1 && w_en && (w_addr == r_addr)) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (w_be[i]) begin
                        rd_word_s[8*i +: 8] = w_data[8*i +: 8];
                    end else begin
                        rd_word_s[8*i +: 8] = mem[r_addr][8*i +: 8];
                    end
                end
            end else begin
                rd_word_s = mem[r_addr];
            end
        end else begin
            rd_word_s = '0;
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        // Output register loads directly from the array read.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= r_fire_s;
                if (r_fire_s) begin
                    r_data <= rd_word_s;
                end
            end
        end
    end else begin : g_lat2
        logic              stage_valid_r;
        logic [DATA_W-1:0] stage_data_r;

        // Stage register captures the read word; later writes cannot alter it.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stage_valid_r <= 1'b0;
                stage_data_r  <= '0;
            end else begin
                stage_valid_r <= r_fire_s;
                if (r_fire_s) begin
                    stage_data_r <= rd_word_s;
                end
            end
        end

        // Output register; holds its last value when no read completes.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= stage_valid_r;
                if (stage_valid_r) begin
                    r_data <= stage_data_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_two_port_ram_be_pipe.sv
// Bench for two_port_ram_be_pipe: four builds (latency 1/2 x write-first/read-first)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_two_port_ram_be_pipe;

    localparam int DW = 32;
    localparam int DP = 100;
    localparam int AW = 7;
    localparam int NI = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [3:0]    w_be;
    logic [DW-1:0] w_data;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] rd [NI];
    logic          rv [NI];

    always #5 clk = ~clk;

    two_port_ram_be_pipe #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RD_LAT(1), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd[0]), .r_valid(rv[0]));
    two_port_ram_be_pipe #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RD_LAT(1), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd[1]), .r_valid(rv[1]));
    two_port_ram_be_pipe #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RD_LAT(2), .BYPASS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd[2]), .r_valid(rv[2]));
    two_port_ram_be_pipe #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RD_LAT(2), .BYPASS(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_en(r_en), .r_addr(r_addr), .r_data(rd[3]), .r_valid(rv[3]));

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] d;
        logic [31:0] m;
    } ent_t;

    // Reference model: word contents plus which bytes have ever been written.
    logic [31:0] mem_m [128];
    logic [3:0]  known [128];
    ent_t        pend [$];
    logic [31:0] last_d [NI];
    logic [31:0] last_m [NI];
    logic        exp_v [NI];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, req);
        end
    endtask

    function automatic logic [31:0] expand(input logic [3:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic int lat_of(input int k);
        return (k < 2) ? 1 : 2;
    endfunction

    function automatic bit bypass_of(input int k);
        return (k == 0 || k == 2);
    endfunction

    // One clock edge: advance the model with the inputs currently applied, then check.
    task automatic tick();
        ent_t e;
        int   hit;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            pend.delete();
            for (int k = 0; k < NI; k++) begin
                exp_v[k]  = 1'b0;
                last_d[k] = 32'h0;
                last_m[k] = 32'hFFFF_FFFF;
            end
        end else begin
            if (r_en) begin
                for (int k = 0; k < NI; k++) begin
                    e.inst = k;
                    e.due  = cyc + lat_of(k) - 1;
                    if (int'(r_addr) >= DP) begin
                        e.d = 32'h0;
                        e.m = 32'hFFFF_FFFF;
                    end else begin
                        e.d = mem_m[r_addr];
                        e.m = expand(known[r_addr]);
                        if (bypass_of(k) && w_en && w_addr == r_addr) begin
                            e.d = (e.d & ~expand(w_be)) | (w_data & expand(w_be));
                            e.m = e.m | expand(w_be);
                        end
                    end
                    pend.push_back(e);
                end
            end
            if (w_en && int'(w_addr) < DP) begin
                mem_m[w_addr] = (mem_m[w_addr] & ~expand(w_be)) | (w_data & expand(w_be));
                known[w_addr] = known[w_addr] | w_be;
            end
            for (int k = 0; k < NI; k++) begin
                exp_v[k] = 1'b0;
                hit = -1;
                for (int j = 0; j < pend.size(); j++)
                    if (hit < 0 && pend[j].inst == k && pend[j].due == cyc) hit = j;
                if (hit >= 0) begin
                    exp_v[k]  = 1'b1;
                    last_d[k] = pend[hit].d;
                    last_m[k] = pend[hit].m;
                    pend.delete(hit);
                end
            end
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("r_valid[%0d]", k), {31'h0, rv[k]}, {31'h0, exp_v[k]});
            chk($sformatf("r_data[%0d]", k), rd[k] & last_m[k], last_d[k] & last_m[k]);
        end
    endtask

    task automatic idle(input int n);
        w_en = 1'b0;
        r_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        w_en = 1'b1; w_addr = AW'(a); w_data = d; w_be = be;
    endtask

    task automatic rdq(input int a);
        r_en = 1'b1; r_addr = AW'(a);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_m[i] = 32'h0;
            known[i] = 4'h0;
        end
        rst_n = 1'b0; w_en = 1'b0; w_addr = '0; w_be = '0; w_data = '0; r_en = 1'b0; r_addr = '0;
        for (int k = 0; k < NI; k++) begin
            exp_v[k] = 1'b0; last_d[k] = 32'h0; last_m[k] = 32'hFFFF_FFFF;
        end

        // Reset three cycles, with requests that must be ignored.
        wr(3, 32'hDEAD_BEEF, 4'hF); rdq(3);
        for (int i = 0; i < 3; i++) tick();
        w_en = 1'b0; r_en = 1'b0;
        rst_n = 1'b1;
        rdq(5); tick(); idle(2);

        // Byte-enable merge.
        wr(10, 32'hAAAA_AAAA, 4'hF); tick();
        wr(10, 32'h5555_5555, 4'h3); tick();
        w_en = 1'b0; rdq(10); tick();
        chk("be_merge_lat1", rd[0], 32'hAAAA_5555);
        r_en = 1'b0; tick();
        chk("be_merge_lat2", rd[3], 32'hAAAA_5555);
        idle(1);

        // Same-address collision.
        wr(7, 32'h1111_1111, 4'hF); tick();
        wr(7, 32'h2222_2222, 4'hF); rdq(7); tick();
        chk("coll_wfirst", rd[0], 32'h2222_2222);
        chk("coll_rfirst", rd[1], 32'h1111_1111);
        w_en = 1'b0; rdq(7); tick();
        chk("coll_wfirst_l2", rd[2], 32'h2222_2222);
        chk("coll_rfirst_l2", rd[3], 32'h1111_1111);
        chk("after_coll", rd[1], 32'h2222_2222);
        idle(2);

        // Streaming writes then back-to-back reads.
        for (int a = 0; a < 16; a++) begin
            wr(a, 32'(a), 4'hF); tick();
        end
        w_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rdq(a); tick();
        end
        idle(3);
        chk("stream_hold", rd[2], 32'd15);

        // Reset while a latency-2 read is in flight.
        wr(20, 32'hCAFE_F00D, 4'hF); tick();
        w_en = 1'b0; rdq(20); tick();
        r_en = 1'b0; rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        rdq(20); tick(); idle(2);

        // Out-of-range addresses.
        wr(120, 32'h1234_5678, 4'hF); tick();
        w_en = 1'b0; rdq(120); tick();
        chk("oor_read", rd[0], 32'h0);
        wr(99, 32'h9999_0001, 4'hF); r_en = 1'b0; tick();
        w_en = 1'b0; rdq(99); tick(); idle(2);

        // Fill the array, then randomized traffic with collisions and resets.
        for (int a = 0; a < DP; a++) begin
            wr(a, $urandom, 4'hF); tick();
        end
        w_en = 1'b0;
        for (int i = 0; i < 800; i++) begin
            w_en   = ($urandom_range(0, 3) != 0);
            w_addr = AW'($urandom_range(0, 127));
            w_be   = 4'($urandom);
            w_data = $urandom;
            r_en   = ($urandom_range(0, 3) != 0);
            r_addr = ($urandom_range(0, 2) == 0) ? w_addr : AW'($urandom_range(0, 127));
            rst_n  = ($urandom_range(0, 40) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/two_port_ram_be_pipe.md
Name: two_port_ram_be_pipe

Overview:
- Parametrised single-clock two-port RAM: one write port, one read port.
- Per-byte write enables, selectable read latency (1 or 2 cycles), a read-valid strobe and a configurable read-during-write policy.
- Next-generation buffer RAM for the VCU datapath. It replaces the fixed 2048x4096 dual-clock instances wherever both ports share a clock domain.

Parameters:
- DATA_W, 2048, data word width in bits; must be a multiple of 8.
- DEPTH, 4096, number of words; need not be a power of two.
- ADDR_W, 12, address width; must satisfy 2^ADDR_W >= DEPTH.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- BYPASS, 1, same-address read/write collision policy: 1 = write-first (new data), 0 = read-first (old data).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- w_en  input  1  write request.
- w_addr  input  ADDR_W  write address.
- w_be  input  DATA_W/8  byte enables; bit i covers w_data[8i+7:8i].
- w_data  input  DATA_W  write data.
- r_en  input  1  read request.
- r_addr  input  ADDR_W  read address.
- r_data  output  DATA_W  read data, registered.
- r_valid  output  1  one-cycle strobe, high when r_data carries the result of a read.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset values:
  - r_valid = 0, r_data = 0, all internal pipeline valid bits = 0.
  - Memory array is not reset; contents persist across reset.
- During reset:
  - While rst_n = 0, w_en and r_en are ignored; no array write occurs.
  - A read in flight when reset asserts is discarded and produces no r_valid.
- Write:
  - w_en = 1 at edge N updates mem[w_addr] at edge N.
  - Only bytes with w_be[i] = 1 are written; other bytes keep their prior value.
  - w_be = 0 with w_en = 1 is a legal no-op.
- Read, RD_LAT = 1:
  - r_en = 1 at edge N drives r_data = mem[r_addr] and r_valid = 1 after edge N.
- Read, RD_LAT = 2:
  - Array output goes into a stage register, then the output register.
  - r_data and r_valid appear after edge N+1.
  - Back-to-back reads give one result per cycle, no bubbles.
- Hold: when no read completes, r_valid = 0 and r_data holds its last value (not cleared).
- Collision (r_en and w_en both 1, r_addr == w_addr, same edge):
  - BYPASS = 1: each returned byte equals w_data if its w_be bit is 1, otherwise the old mem byte.
  - BYPASS = 0: the returned word is the old mem content, unaffected by the concurrent write.
- No collision effect for:
  - writes on earlier edges, which are always visible to later reads;
  - a write landing while a RD_LAT = 2 read is in its second stage. The captured data stands.
- Out-of-range addresses (address >= DEPTH):
  - writes are dropped;
  - reads return all-zero data with r_valid = 1.
- Never stalls; no backpressure. Both ports can be active every cycle.
- Elaboration errors: RD_LAT not in {1, 2}, DATA_W % 8 != 0, or 2^ADDR_W < DEPTH.

Test Plan:
1. Reset then read:
   - rst_n low 3 cycles; release; read addr 5 (RD_LAT = 1) -> r_valid high exactly 1 cycle after r_en.
   - r_data = 0 during reset; value after the read is don't-care (uninitialised array).
2. Byte-enable merge:
   - Write addr 10 with all bytes 0xAA, full w_be.
   - Then write addr 10 with data 0x55 bytes, w_be = 0x...0003.
   - Read addr 10 -> bytes 0 and 1 = 0x55, all other bytes = 0xAA.
3. Collision, BYPASS = 1 vs BYPASS = 0:
   - Preload addr 7 = 0x11 bytes.
   - Same edge: write 0x22 bytes with full w_be, and read addr 7.
   - BYPASS = 1 -> 0x22 bytes; BYPASS = 0 -> 0x11 bytes.
   - Next read of addr 7 -> 0x22 bytes in both builds.
4. RD_LAT = 2 streaming:
   - Write addrs 0..15 with data = addr.
   - Issue 16 consecutive reads of 0..15 -> r_valid high 16 consecutive cycles starting 2 cycles after the first r_en; r_data = 0..15 in order.
   - r_data holds 15 afterwards with r_valid = 0.
5. Reset mid-read, RD_LAT = 2:
   - r_en at cycle N, rst_n low at cycle N+1 -> no r_valid pulse; r_data = 0.
   - Memory content written before reset is still readable after release.
6. Out-of-range, DEPTH = 100, ADDR_W = 7:
   - Write addr 120 -> no array change.
   - Read addr 120 -> r_data = 0, r_valid = 1.
   - Read addr 99 -> last data written there.
